// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle MIPS controller (master) and the datapath (slave).
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             pc_we;
  logic             iord;
  logic             mem_rd;
  logic             mem_wr;
  logic             ir_we;
  logic             reg_we;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_src;
  logic [3:0]       state;
  logic             instr_done;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  // Memory handshake: mem_rd/mem_wr are held every cycle of an access and
  // the access completes in the cycle where mem_ready is sampled high.
  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, iord, mem_rd, mem_wr, ir_we, reg_we, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, state, instr_done, illegal,
           instr_count
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, iord, mem_rd, mem_wr, ir_we, reg_we, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, state, instr_done, illegal,
           instr_count
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM; outputs decode combinationally from state, zero and mem_ready.
// Optional retired-instruction counter enabled by defining MC_CTRL_PERF_EN.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_JAL      = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  state_e     state_q, state_d;
  logic       pc_we, iord, mem_rd, mem_wr, ir_we, reg_we, alu_src_a;
  logic       instr_done, illegal;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_we      = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_R:           state_d = S_R_EXEC;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_I_EXEC;
          OP_J:           state_d = S_JUMP;
          OP_JAL:         state_d = S_JAL;
          default:        state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_rd  = 1'b1;
        iord    = 1'b1;
        state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_wr     = 1'b1;
        iord       = 1'b1;
        instr_done = bus.mem_ready;
        state_d    = bus.mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_we     = 1'b1;
        reg_dst    = 2'b01;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        // ALUOut already holds the target computed during DECODE.
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_we      = (bus.opcode == OP_BEQ) ? bus.zero : ~bus.zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        pc_src     = 2'b10;
        pc_we      = 1'b1;
        reg_we     = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        instr_done = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset silences every output in the same cycle, even mid memory access.
    if (!rst_n) begin
      pc_we      = 1'b0;
      iord       = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign bus.pc_we      = pc_we;
  assign bus.iord       = iord;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wr     = mem_wr;
  assign bus.ir_we      = ir_we;
  assign bus.reg_we     = reg_we;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.pc_src     = pc_src;
  assign bus.state      = state_q;
  assign bus.instr_done = instr_done;
  assign bus.illegal    = illegal;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (instr_done) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= {CNT_W{1'b0}};
    else        cnt_q <= cnt_d;
  end

  assign bus.instr_count = cnt_q;
`else
  assign bus.instr_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed vector table, instruction-level random model, reset/trap sequences.
module tb_mips_multicycle_ctrl;
  localparam int CNT_W = 32;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_done_cnt = 0;
  logic [5:0] cur_opc;
  logic       cur_z;

  mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [22:0] dut_vec();
    return {bus.pc_we, bus.iord, bus.mem_rd, bus.mem_wr, bus.ir_we, bus.reg_we,
            bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_src, bus.state, bus.instr_done, bus.illegal};
  endfunction

  // Per-state control word, read straight from the state table of the controller description.
  function automatic logic [22:0] exp_vec(input int st, input logic rdy, input logic z,
                                          input logic [5:0] opc);
    logic pw, io, mr, mw, iw, rw, a, dn, il;
    logic [1:0] rd, m2r, b, op, ps;
    {pw, io, mr, mw, iw, rw, a, dn, il} = '0;
    {rd, m2r, b, op, ps} = '0;
    case (st)
      0:  begin mr = 1; b = 2'b01; iw = rdy; pw = rdy; end
      1:  b = 2'b11;
      2:  begin a = 1; b = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 2'b01; dn = 1; end
      5:  begin mw = 1; io = 1; dn = rdy; end
      6:  begin a = 1; op = 2'b10; end
      7:  begin rw = 1; rd = 2'b01; dn = 1; end
      8:  begin a = 1; op = 2'b01; ps = 2'b01; pw = (opc == 6'h04) ? z : ~z; dn = 1; end
      9:  begin ps = 2'b10; pw = 1; dn = 1; end
      10: begin a = 1; b = 2'b10; end
      11: begin rw = 1; dn = 1; end
      12: begin ps = 2'b10; pw = 1; rw = 1; rd = 2'b10; m2r = 2'b10; dn = 1; end
      13: il = 1;
      default: ;
    endcase
    return {pw, io, mr, mw, iw, rw, rd, m2r, a, b, op, ps, 4'(st), dn, il};
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef MC_CTRL_PERF_EN
    return CNT_W'(exp_done_cnt);
`else
    return '0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic rdy, input logic [22:0] exp, input string nm);
    @(negedge clk);
    bus.mem_ready = rdy;
    #1;
    check(nm, {41'b0, dut_vec()}, {41'b0, exp});
    if (exp[1]) exp_done_cnt++;
  endtask

  task automatic mem_phase(input int st);
    int w;
    w = $urandom_range(0, 3);
    for (int i = 0; i < w; i++) step(1'b0, exp_vec(st, 1'b0, cur_z, cur_opc), "rnd_wait");
    step(1'b1, exp_vec(st, 1'b1, cur_z, cur_opc), "rnd_ready");
  endtask

  task automatic plain_phase(input int st);
    logic r;
    r = 1'($urandom_range(0, 1));
    step(r, exp_vec(st, r, cur_z, cur_opc), "rnd_state");
  endtask

  // Instruction-level model: each opcode expands to its sequence of phases.
  task automatic run_model_instr(input logic [5:0] opc);
    cur_opc = opc;
    cur_z   = 1'($urandom_range(0, 1));
    bus.opcode = opc;
    bus.funct  = 6'($urandom);
    bus.zero   = cur_z;
    mem_phase(0);
    plain_phase(1);
    case (opc)
      6'h23: begin plain_phase(2); mem_phase(3); plain_phase(4); end
      6'h2b: begin plain_phase(2); mem_phase(5); end
      6'h00: begin plain_phase(6); plain_phase(7); end
      6'h04, 6'h05: plain_phase(8);
      6'h08: begin plain_phase(10); plain_phase(11); end
      6'h02: plain_phase(9);
      6'h03: plain_phase(12);
      default: plain_phase(13);
    endcase
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic        z;
    logic [15:0] rdy;
    int          cyc;
    logic [3:0]  st;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  m2r;
    logic        mem_wr;
  } vec_t;

  vec_t tbl[11];

  task automatic run_entry(input vec_t e);
    int cycles;
    logic done;
    logic [12:0] got;
    bus.opcode = e.opc;
    bus.funct  = e.fn;
    bus.zero   = e.z;
    cycles = 0;
    done   = 1'b0;
    got    = '0;
    while (!done && cycles < 20) begin
      @(negedge clk);
      bus.mem_ready = e.rdy[cycles];
      #1;
      cycles++;
      if (bus.instr_done) begin
        done = 1'b1;
        got  = {bus.state, bus.pc_we, bus.pc_src, bus.reg_we, bus.reg_dst, bus.mem_to_reg,
                bus.mem_wr};
      end
    end
    check({e.name, "_cycles"}, 64'(cycles), 64'(e.cyc));
    check({e.name, "_final"}, {51'b0, got},
          {51'b0, e.st, e.pc_we, e.pc_src, e.reg_we, e.reg_dst, e.m2r, e.mem_wr});
    exp_done_cnt++;
  endtask

  // ---------------- main sequence ----------------
  logic [5:0] ops[8];

  initial begin
    tbl[0]  = '{"add",      6'h00, 6'h20, 1'b0, 16'hFFFF, 4, 4'd7,  1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0};
    tbl[1]  = '{"lw_wait",  6'h23, 6'h00, 1'b0, 16'h0048, 8, 4'd4,  1'b0, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0};
    tbl[2]  = '{"sw",       6'h2b, 6'h00, 1'b0, 16'hFFFF, 4, 4'd5,  1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1};
    tbl[3]  = '{"sw_wait",  6'h2b, 6'h00, 1'b1, 16'h0021, 6, 4'd5,  1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1};
    tbl[4]  = '{"beq_z1",   6'h04, 6'h00, 1'b1, 16'hFFFF, 3, 4'd8,  1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[5]  = '{"beq_z0",   6'h04, 6'h00, 1'b0, 16'hFFFF, 3, 4'd8,  1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[6]  = '{"bne_z0",   6'h05, 6'h00, 1'b0, 16'hFFFF, 3, 4'd8,  1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[7]  = '{"bne_z1",   6'h05, 6'h00, 1'b1, 16'hFFFF, 3, 4'd8,  1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[8]  = '{"addi",     6'h08, 6'h00, 1'b0, 16'hFFFF, 4, 4'd11, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0};
    tbl[9]  = '{"j",        6'h02, 6'h00, 1'b0, 16'hFFFF, 3, 4'd9,  1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[10] = '{"jal",      6'h03, 6'h00, 1'b0, 16'hFFFF, 3, 4'd12, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10, 1'b0};
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02, 6'h03};

    rst_n         = 1'b0;
    bus.opcode    = '0;
    bus.funct     = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    cur_opc       = '0;
    cur_z         = 1'b0;

    // Reset state: everything silent, including mem_rd, even with mem_ready high.
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {41'b0, dut_vec()}, 64'd0);
    check("reset_count", 64'(bus.instr_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check("release_fetch", {41'b0, dut_vec()}, {41'b0, exp_vec(0, 1'b0, 1'b0, 6'h00)});
    exp_done_cnt = 0;

    for (int i = 0; i < 11; i++) run_entry(tbl[i]);
    check("table_count", 64'(bus.instr_count), 64'(exp_cnt()));

    for (int i = 0; i < 40; i++) run_model_instr(ops[$urandom_range(0, 7)]);
    check("random_count", 64'(bus.instr_count), 64'(exp_cnt()));

    // Reset while a store is waiting on memory.
    cur_opc = 6'h2b; cur_z = 1'b0;
    bus.opcode = 6'h2b;
    step(1'b1, exp_vec(0, 1'b1, 1'b0, 6'h2b), "sw_fetch");
    step(1'b0, exp_vec(1, 1'b0, 1'b0, 6'h2b), "sw_decode");
    step(1'b0, exp_vec(2, 1'b0, 1'b0, 6'h2b), "sw_addr");
    step(1'b0, exp_vec(5, 1'b0, 1'b0, 6'h2b), "sw_wr_wait");
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {41'b0, dut_vec()}, 64'd0);
    check("abort_count", 64'(bus.instr_count), 64'd0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("abort_hold", {41'b0, dut_vec()}, 64'd0);
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check("abort_release", {41'b0, dut_vec()}, {41'b0, exp_vec(0, 1'b0, 1'b0, 6'h2b)});
    exp_done_cnt = 0;
    step(1'b0, exp_vec(0, 1'b0, 1'b0, 6'h2b), "abort_fetch_hold");

    // lw, add, beq retire, then an illegal opcode traps and freezes the count.
    run_model_instr(6'h23);
    run_model_instr(6'h00);
    run_model_instr(6'h04);
    check("pre_trap_count", 64'(exp_done_cnt), 64'd3);
    run_model_instr(6'h3f);
    for (int i = 0; i < 20; i++) plain_phase(13);
    check("trap_count", 64'(bus.instr_count), 64'(exp_cnt()));
    #1;
    rst_n = 1'b0;
    #1;
    check("trap_reset_illegal", 64'(bus.illegal), 64'd0);
    check("trap_reset_count", 64'(bus.instr_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check("trap_release", {41'b0, dut_vec()}, {41'b0, exp_vec(0, 1'b0, 1'b0, 6'h3f)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
